// File: rtl/debug_loader_pkg.sv
// Shared constants, widths and state encoding for the debug loader.
package mips_debug_pkg;

    localparam int unsigned NB_ADDR        = 32;
    localparam int unsigned NB_INST        = 32;
    localparam int unsigned NB_DATA        = 32;
    localparam int unsigned NB_REG         = 5;
    localparam int unsigned NB_BYTE        = 8;
    localparam int unsigned BYTES_PER_WORD = NB_INST / NB_BYTE;
    localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    localparam logic [NB_BYTE-1:0] CMD_LOAD     = 8'h01;
    localparam logic [NB_BYTE-1:0] CMD_RUN      = 8'h02;
    localparam logic [NB_BYTE-1:0] CMD_STEP     = 8'h03;
    localparam logic [NB_BYTE-1:0] CMD_READ_REG = 8'h04;
    localparam logic [NB_BYTE-1:0] ACK_BYTE     = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LD_CNT,
        ST_LD_BYTE,
        ST_LD_WRITE,
        ST_ACK,
        ST_RUN,
        ST_STEP,
        ST_RD_IDX,
        ST_RD_WAIT,
        ST_RD_SEND
    } state_t;

    // States in which a host byte may be accepted.
    function automatic logic rx_ready_for(state_t s);
        return s inside {ST_IDLE, ST_LD_CNT, ST_LD_BYTE, ST_RD_IDX};
    endfunction

endpackage

// File: rtl/debug_loader_if.sv
// Host link, instruction-memory load and debug-read signals between loader and its peers.
interface debug_loader_if;
    import mips_debug_pkg::*;

    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic               o_rx_ready;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               o_imem_write;
    logic [NB_ADDR-1:0] o_imem_addr;
    logic [NB_INST-1:0] o_imem_data;
    logic               o_cpu_enable;
    logic               i_halt;
    logic [NB_REG-1:0]  o_reg_addr;
    logic [NB_DATA-1:0] i_reg_data;
    logic               o_busy;

    // Loader side.
    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_reg_data,
        output o_rx_ready, o_tx_data, o_tx_valid, o_imem_write, o_imem_addr,
               o_imem_data, o_cpu_enable, o_reg_addr, o_busy
    );

    // Host adapter / core side.
    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_reg_data,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_imem_write, o_imem_addr,
               o_imem_data, o_cpu_enable, o_reg_addr, o_busy
    );

endinterface

// File: rtl/debug_loader_word_serializer.sv
// Sends a 32-bit word as four bytes, MSB first, over a valid/ready link.
module word_serializer
    import mips_debug_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [NB_DATA-1:0] word,
    output logic [NB_BYTE-1:0] data,
    output logic               valid,
    input  logic               ready,
    output logic               done_c
);

    logic [NB_DATA-1:0]    shift_q;
    logic [BYTE_IDX_W-1:0] idx_q;

    // Load the word, then shift one byte out per accepted handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            shift_q <= word;
            idx_q   <= '0;
            valid   <= 1'b1;
        end else if (valid && ready) begin
            if (idx_q == LAST_BYTE_IDX) begin
                valid <= 1'b0;
            end else begin
                shift_q <= {shift_q[NB_DATA-NB_BYTE-1:0], NB_BYTE'(0)};
                idx_q   <= idx_q + BYTE_IDX_W'(1);
            end
        end
    end

    assign data   = shift_q[NB_DATA-1 -: NB_BYTE];
    assign done_c = valid && ready && (idx_q == LAST_BYTE_IDX);

endmodule

// File: rtl/debug_loader.sv
// Byte-serial host command decoder driving instruction load, run/step and register readback.
module debug_loader
    import mips_debug_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_reset,
    debug_loader_if.master bus
);

    state_t                state, state_nxt;
    logic                  rx_ready_q;
    logic                  ack_valid_q;
    logic                  imem_write_q;
    logic                  cpu_en_q;
    logic                  busy_q;
    logic [NB_ADDR-1:0]    addr_cnt;
    logic [BYTE_IDX_W-1:0] byte_cnt;
    logic [NB_BYTE-1:0]    word_cnt;
    logic [NB_INST-1:0]    word_sr;
    logic [NB_REG-1:0]     reg_addr_q;

    logic                  rx_fire;
    logic [NB_BYTE-1:0]    ser_data;
    logic                  ser_valid;
    logic                  ser_done;

    assign rx_fire = bus.i_rx_valid && rx_ready_q;

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rx_fire) begin
                    case (bus.i_rx_data)
                        CMD_LOAD:     state_nxt = ST_LD_CNT;
                        CMD_RUN:      state_nxt = ST_RUN;
                        CMD_STEP:     state_nxt = ST_STEP;
                        CMD_READ_REG: state_nxt = ST_RD_IDX;
                        default:      state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_LD_CNT: begin
                if (rx_fire) state_nxt = (bus.i_rx_data == '0) ? ST_ACK : ST_LD_BYTE;
            end
            ST_LD_BYTE: begin
                if (rx_fire && byte_cnt == LAST_BYTE_IDX) state_nxt = ST_LD_WRITE;
            end
            ST_LD_WRITE: state_nxt = (word_cnt == NB_BYTE'(1)) ? ST_ACK : ST_LD_BYTE;
            ST_ACK: begin
                if (bus.i_tx_ready) state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.i_halt) state_nxt = ST_ACK;
            end
            ST_STEP:    state_nxt = ST_ACK;
            ST_RD_IDX: begin
                if (rx_fire) state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: state_nxt = ST_RD_SEND;
            ST_RD_SEND: begin
                if (ser_done) state_nxt = ST_IDLE;
            end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // State, registered outputs and load/read datapath.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= ST_IDLE;
            rx_ready_q   <= 1'b1;
            ack_valid_q  <= 1'b0;
            imem_write_q <= 1'b0;
            cpu_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            addr_cnt     <= '0;
            byte_cnt     <= '0;
            word_cnt     <= '0;
            word_sr      <= '0;
            reg_addr_q   <= '0;
        end else begin
            state        <= state_nxt;
            rx_ready_q   <= rx_ready_for(state_nxt);
            ack_valid_q  <= (state_nxt == ST_ACK);
            imem_write_q <= (state_nxt == ST_LD_WRITE);
            cpu_en_q     <= (state_nxt inside {ST_RUN, ST_STEP});
            busy_q       <= (state_nxt != ST_IDLE);
            case (state)
                ST_LD_CNT: begin
                    if (rx_fire) begin
                        word_cnt <= bus.i_rx_data;
                        addr_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_LD_BYTE: begin
                    if (rx_fire) begin
                        word_sr  <= {word_sr[NB_INST-NB_BYTE-1:0], bus.i_rx_data};
                        byte_cnt <= byte_cnt + BYTE_IDX_W'(1);
                    end
                end
                ST_LD_WRITE: begin
                    addr_cnt <= addr_cnt + NB_ADDR'(BYTES_PER_WORD);
                    word_cnt <= word_cnt - NB_BYTE'(1);
                end
                ST_RD_IDX: begin
                    if (rx_fire) reg_addr_q <= bus.i_rx_data[NB_REG-1:0];
                end
                default: ;
            endcase
        end
    end

    // Register readback is captured at the end of RD_WAIT and streamed out.
    word_serializer u_ser (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .load   (state == ST_RD_WAIT),
        .word   (bus.i_reg_data),
        .data   (ser_data),
        .valid  (ser_valid),
        .ready  (bus.i_tx_ready),
        .done_c (ser_done)
    );

    assign bus.o_rx_ready   = rx_ready_q;
    assign bus.o_tx_valid   = ack_valid_q | ser_valid;
    assign bus.o_tx_data    = ack_valid_q ? ACK_BYTE : ser_data;
    assign bus.o_imem_write = imem_write_q;
    assign bus.o_imem_addr  = addr_cnt;
    assign bus.o_imem_data  = word_sr;
    // Halt gates the enable in the same cycle it is seen.
    assign bus.o_cpu_enable = cpu_en_q & ~bus.i_halt;
    assign bus.o_reg_addr   = reg_addr_q;
    assign bus.o_busy       = busy_q;

endmodule

// File: doc/debug_loader.md
Name: debug_loader

Overview:
- Host-side debug controller for top_mips; drives the processor's instruction-load and debug-read interface (write strobe, address, instruction, enable, register-read address / read data).
- Accepts a byte-serial command stream from a host link (valid/ready). Loads program words into instruction memory, starts or single-steps the core, and returns register contents as a byte stream.
- Sits between the UART/host adapter and top_mips.

Parameters:
- NB_ADDR, 32, instruction-memory address width (byte address, word aligned).
- NB_INST, 32, instruction word width; must be 32 (4 bytes).
- NB_DATA, 32, register read-data width; must be 32.
- NB_REG, 5, register index width.
- NB_BYTE, 8, host byte width.

Ports:
- i_clk in 1: system clock.
- i_reset in 1: synchronous, active-low reset.
- i_rx_data in 8: command/data byte from host.
- i_rx_valid in 1: i_rx_data valid.
- o_rx_ready out 1: block accepts a byte; transfer occurs when valid&&ready.
- o_tx_data out 8: response byte.
- o_tx_valid out 1: o_tx_data valid.
- i_tx_ready in 1: host accepts response; transfer occurs when valid&&ready.
- o_imem_write out 1: instruction-memory write strobe (one cycle per word).
- o_imem_addr out NB_ADDR: write address.
- o_imem_data out NB_INST: instruction word.
- o_cpu_enable out 1: core clock-enable.
- i_halt in 1: core has retired a HALT (32'h0).
- o_reg_addr out NB_REG: debug register-read index.
- i_reg_data in NB_DATA: register content; valid one cycle after o_reg_addr changes.
- o_busy out 1: high in every state except IDLE.

Behaviour:
- Reset (i_reset==0 at rising edge): state IDLE. All outputs 0 except o_rx_ready=1. Address counter 0, byte counter 0, word counter 0.
- Reset mid-operation: abort immediately. Any partially assembled word is discarded. o_cpu_enable drops the next cycle.
- Command opcodes (first byte in IDLE): 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 READ_REG. Any other byte is consumed and ignored; state stays IDLE.
- IDLE --0x01--> LD_CNT.
- LD_CNT: the next byte is word count N (0..255); the address counter clears to 0.
  - N==0: go to ACK.
  - Otherwise go to LD_BYTE.
- LD_BYTE: assemble 4 bytes big-endian (first byte = bits 31:24).
  - After the 4th byte, go to LD_WRITE.
  - o_rx_ready=1 throughout LD_BYTE.
- LD_WRITE: one cycle.
  - o_imem_write=1, o_imem_addr=counter, o_imem_data=assembled word. o_rx_ready=0.
  - Counter += 4, N -= 1.
  - N reaches 0: go to ACK; otherwise back to LD_BYTE.
- ACK: o_tx_data=0xA5, o_tx_valid=1. Hold until i_tx_ready, then go to IDLE. o_rx_ready=0.
- IDLE --0x02--> RUN.
  - RUN: o_cpu_enable=1 each cycle while i_halt==0.
  - i_halt==1: deassert o_cpu_enable the same cycle (combinational gate), then go to ACK.
  - RUN ignores rx bytes (o_rx_ready=0).
- IDLE --0x03--> STEP.
  - STEP: o_cpu_enable=1 for exactly one cycle, then go to ACK.
  - If i_halt is already 1, no pulse is issued; go straight to ACK.
- IDLE --0x04--> RD_IDX.
  - RD_IDX: the next byte's low 5 bits latch into o_reg_addr; upper 3 bits are ignored. Go to RD_WAIT.
  - RD_WAIT: one cycle; capture i_reg_data into the shift register at the end of the cycle. Go to RD_SEND.
  - RD_SEND: send 4 bytes MSB first. Each byte holds on o_tx_data/o_tx_valid until i_tx_ready. After the 4th handshake go to IDLE (no 0xA5 for reads).
- o_rx_ready=1 only in IDLE, LD_CNT, LD_BYTE, RD_IDX.
- o_tx_valid=1 only in ACK and RD_SEND.
- Address wrap: counter is NB_ADDR wide and wraps naturally. Max load is 255 words, so it never wraps in practice.
- No timeouts. A stalled host leaves the FSM waiting indefinitely.

Decomposition:
- Shared package mips_debug_pkg: opcode constants (CMD_LOAD, CMD_RUN, CMD_STEP, CMD_READ_REG), ACK byte 0xA5, state encoding.
- One sub-module: word_serializer, a 32-bit to 4×8-bit MSB-first transmitter with valid/ready, used by RD_SEND.
- Word assembly stays inline.

Test Plan:
- Reset held low 3 cycles mid-LD_BYTE, then released -> all outputs 0, o_rx_ready=1, o_busy=0; the next LOAD writes from address 0.
- LOAD: bytes 01,02,00,22,20,20,00,00,00,00 (i_tx_ready=1) -> writes 32'h00222020 @0 and 32'h00000000 @4, one o_imem_write cycle each; then one 0xA5.
- LOAD with N=0 (01,00) -> no o_imem_write; 0xA5 returned.
- STEP (03) -> o_cpu_enable high exactly 1 cycle, then 0xA5. RUN (02) with i_halt asserted 10 cycles later -> o_cpu_enable high 10 cycles, low at halt, then 0xA5.
- READ_REG: bytes 04,02 with i_reg_data=32'h00000003 -> o_reg_addr=2; tx bytes 00,00,00,03.
- Backpressure: i_tx_ready low 5 cycles during RD_SEND -> o_tx_data stable and o_tx_valid held; no byte lost or duplicated. Unknown opcode 0x7F in IDLE -> consumed, no output.
